// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds payload and valid stable until that edge, and
// ready may depend combinationally on the consumer's state.
// master = producer of operands / consumer of results, slave = the adder.
interface pipelined_adder_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   modport master (
      output in_valid, a, b, op, cin, out_ready,
      input  in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
   );

   modport slave (
      input  in_valid, a, b, op, cin, out_ready,
      output in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into WIDTH/CHUNK ripple stages.
// An input register captures operands (B already inverted for SUB/SBC and the
// effective carry-in), then stage k resolves bits [k*CHUNK +: CHUNK] and
// passes carry, the partially resolved word and B on to the next stage.
// The last stage writes the output register, so latency is STAGES cycles.
// Optional feature macro: ADDER_FLAGS_EN (NZCV flags; otherwise tied to 0).
// Every register advances together on a single advance signal
// (out_ready | ~out_valid), so a stalled output freezes the whole pipe.
module pipelined_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input logic             clk,
   input logic             reset_n,
   pipelined_adder_if.slave io_bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
   end

   logic             w_advance;
   logic [WIDTH-1:0] w_eff_b;
   logic             w_cin_eff;

   // Per-stage input registers. r_a holds resolved sum chunks below the
   // stage's chunk and untouched operand A chunks from it upward.
   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic             r_c   [STAGES];

   logic [CHUNK:0]   w_part [STAGES];
   logic [WIDTH-1:0] w_res  [STAGES];

   logic             r_out_vld;
   logic [WIDTH-1:0] r_sum;

   assign w_advance       = io_bus.out_ready | ~r_out_vld;
   assign io_bus.in_ready  = w_advance;
   assign io_bus.out_valid = r_out_vld;
   assign io_bus.sum       = r_sum;

   // Operand conditioning: invert B for subtracts, pick the effective carry-in.
   always_comb begin
      w_eff_b   = io_bus.op[0] ? ~io_bus.b : io_bus.b;
      w_cin_eff = 1'b0;
      case (io_bus.op)
         2'b00:   w_cin_eff = 1'b0;
         2'b01:   w_cin_eff = 1'b1;
         default: w_cin_eff = io_bus.cin;
      endcase
   end

   // Each stage ripples its own CHUNK bits from its registered carry.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_part[k] = {1'b0, r_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, r_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_c[k]};
         w_res[k]  = r_a[k];
         w_res[k][k*CHUNK +: CHUNK] = w_part[k][CHUNK-1:0];
      end
   end

   // Pipeline shift: input capture, stage-to-stage transfer and output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_c[k]   <= 1'b0;
         end
         r_out_vld <= 1'b0;
         r_sum     <= '0;
      end else if (w_advance) begin
         r_vld[0] <= io_bus.in_valid;
         r_a[0]   <= io_bus.a;
         r_b[0]   <= w_eff_b;
         r_c[0]   <= w_cin_eff;
         for (int k = 1; k < STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_a[k]   <= w_res[k-1];
            r_b[k]   <= r_b[k-1];
            r_c[k]   <= w_part[k-1][CHUNK];
         end
         r_out_vld <= r_vld[LAST];
         r_sum     <= w_res[LAST];
      end
   end

`ifdef ADDER_FLAGS_EN
   logic r_z [STAGES];
   logic w_chunk_zero [STAGES];
   logic w_msb_cin;
   logic r_flag_n;
   logic r_flag_z;
   logic r_flag_c;
   logic r_flag_v;

   // Running zero per stage; carry into the MSB recovered from a^b^sum at bit WIDTH-1.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_chunk_zero[k] = r_z[k] & (w_part[k][CHUNK-1:0] == '0);
      end
      w_msb_cin = r_a[LAST][WIDTH-1] ^ r_b[LAST][WIDTH-1] ^ w_res[LAST][WIDTH-1];
   end

   // Flag pipeline: running-zero chain and the NZCV output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_z[k] <= 1'b0;
         end
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_v <= 1'b0;
      end else if (w_advance) begin
         r_z[0] <= 1'b1;
         for (int k = 1; k < STAGES; k++) begin
            r_z[k] <= w_chunk_zero[k-1];
         end
         r_flag_n <= w_res[LAST][WIDTH-1];
         r_flag_z <= w_chunk_zero[LAST];
         r_flag_c <= w_part[LAST][CHUNK];
         r_flag_v <= w_msb_cin ^ w_part[LAST][CHUNK];
      end
   end

   assign io_bus.flag_n = r_flag_n;
   assign io_bus.flag_z = r_flag_z;
   assign io_bus.flag_c = r_flag_c;
   assign io_bus.flag_v = r_flag_v;
`else
   assign io_bus.flag_n = 1'b0;
   assign io_bus.flag_z = 1'b0;
   assign io_bus.flag_c = 1'b0;
   assign io_bus.flag_v = 1'b0;
`endif

endmodule
